// File: rtl/reg_bank_8x8_if.sv
// Bus between the 8x8 register bank and its user: write port, inc/dec port
// and the eight parallel register outputs plus the wrap flag.
interface reg_bank_8x8_if #(
    parameter int WIDTH = 8
);
    logic             WE;
    logic [2:0]       WA;
    logic [WIDTH-1:0] WD;
    logic             IncEn;
    logic             DecEn;
    logic [2:0]       IA;
    logic [WIDTH-1:0] A, B, C, D, E, F, G, H;
    logic             Wrap;

    modport master (
        output WE, WA, WD, IncEn, DecEn, IA,
        input  A, B, C, D, E, F, G, H, Wrap
    );

    modport slave (
        input  WE, WA, WD, IncEn, DecEn, IA,
        output A, B, C, D, E, F, G, H, Wrap
    );
endinterface

// File: rtl/reg_bank_8x8.sv
// Eight-entry register bank with one write port and one inc/dec port; all
// entries are driven in parallel toward the downstream operand mux.
module reg_bank_8x8_entry #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             step,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);
    // Write has priority; the top only raises both on different entries anyway.
    always_ff @(posedge Clk) begin
        if (Rst)
            q <= RST_VAL;
        else if (wr)
            q <= wd;
        else if (step)
            q <= dec ? q - WIDTH'(1) : q + WIDTH'(1);
    end
endmodule

module reg_bank_8x8 #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           Clk,
    input  logic           Rst,
    reg_bank_8x8_if.slave  bus
);
    localparam int NUM_REGS = 8;

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            wr_sel;
    logic [NUM_REGS-1:0]            step_sel;
    logic                           step_req;
    logic                           collide;
    logic                           step_eff;
    logic [WIDTH-1:0]               step_cur;
    logic                           wraps;
    logic                           wrap_q;

    // 1,1 and 0,0 both mean "no request"; a same-address write swallows the step.
    assign step_req = bus.IncEn ^ bus.DecEn;
    assign collide  = bus.WE && step_req && (bus.WA == bus.IA);
    assign step_eff = step_req && !collide;

    assign step_cur = regs[bus.IA];
    assign wraps    = bus.DecEn ? (step_cur == '0) : (step_cur == '1);

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            assign wr_sel[i]   = bus.WE   && (bus.WA == 3'(i));
            assign step_sel[i] = step_eff && (bus.IA == 3'(i));

            reg_bank_8x8_entry #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_entry (
                .Clk  (Clk),
                .Rst  (Rst),
                .wr   (wr_sel[i]),
                .wd   (bus.WD),
                .step (step_sel[i]),
                .dec  (bus.DecEn),
                .q    (regs[i])
            );
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst)
            wrap_q <= 1'b0;
        else if (step_eff)
            wrap_q <= wraps;
    end

    assign bus.A    = regs[0];
    assign bus.B    = regs[1];
    assign bus.C    = regs[2];
    assign bus.D    = regs[3];
    assign bus.E    = regs[4];
    assign bus.F    = regs[5];
    assign bus.G    = regs[6];
    assign bus.H    = regs[7];
    assign bus.Wrap = wrap_q;
endmodule

// File: tb/tb_reg_bank_8x8.sv
// Directed plus random checks of reg_bank_8x8 against a behavioural model,
// with expected bank states queued at drive time and compared after the edge.
module tb_reg_bank_8x8;
    typedef struct packed {
        logic [7:0][7:0] r;
        logic            wrap;
    } state_t;

    logic   Clk = 1'b0;
    logic   Rst;
    state_t model;
    state_t exp_q[$];
    int     total  = 0;
    int     passed = 0;

    reg_bank_8x8_if #(.WIDTH(8)) bus ();

    reg_bank_8x8 #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] dut_reg(input int s);
        case (s)
            0: return bus.A;
            1: return bus.B;
            2: return bus.C;
            3: return bus.D;
            4: return bus.E;
            5: return bus.F;
            6: return bus.G;
            default: return bus.H;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour: inc/dec evaluated on old contents, write wins a collision.
    function automatic state_t next_state(input state_t s, input logic rst, input logic we,
                                          input logic [2:0] wa, input logic [7:0] wd,
                                          input logic inc, input logic dec, input logic [2:0] ia);
        state_t n = s;
        if (rst) begin
            n.r    = '0;
            n.wrap = 1'b0;
        end else begin
            if ((inc != dec) && !(we && wa == ia)) begin
                n.r[ia] = inc ? s.r[ia] + 8'd1 : s.r[ia] - 8'd1;
                n.wrap  = inc ? (s.r[ia] == 8'hFF) : (s.r[ia] == 8'h00);
            end
            if (we) n.r[wa] = wd;
        end
        return n;
    endfunction

    task automatic step(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic inc, input logic dec,
                        input logic [2:0] ia);
        state_t e;
        Rst       = rst;
        bus.WE    = we;
        bus.WA    = wa;
        bus.WD    = wd;
        bus.IncEn = inc;
        bus.DecEn = dec;
        bus.IA    = ia;
        model = next_state(model, rst, we, wa, wd, inc, dec, ia);
        exp_q.push_back(model);
        @(posedge Clk);
        #1;
        Rst    = 1'b0;
        bus.WE = 1'b0; bus.IncEn = 1'b0; bus.DecEn = 1'b0;
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++)
            chk($sformatf("sb_reg%0d", k), dut_reg(k), e.r[k]);
        chk("sb_wrap", {7'd0, bus.Wrap}, {7'd0, e.wrap});
    endtask

    initial begin
        model = 'x;
        Rst = 1'b0; bus.WE = 1'b0; bus.WA = '0; bus.WD = '0;
        bus.IncEn = 1'b0; bus.DecEn = 1'b0; bus.IA = '0;
        @(negedge Clk);

        // 1: reset, then write D
        step(1, 0, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 8; k++) chk("rst_reg", dut_reg(k), 8'h00);
        chk("rst_wrap", {7'd0, bus.Wrap}, 8'h00);
        step(0, 1, 3, 8'h5A, 0, 0, 0);
        chk("wr_D", bus.D, 8'h5A);
        chk("wr_A_hold", bus.A, 8'h00);

        // 2: inc wrap FF->00 then 00->01
        step(0, 1, 2, 8'hFF, 0, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0, 2);
        chk("inc_wrap_C", bus.C, 8'h00);
        chk("inc_wrap_flag", {7'd0, bus.Wrap}, 8'h01);
        step(0, 0, 0, 8'h00, 1, 0, 2);
        chk("inc_C", bus.C, 8'h01);
        chk("inc_flag_clr", {7'd0, bus.Wrap}, 8'h00);

        // 3: dec wrap 00->FF, then both enables = no request
        step(0, 0, 0, 8'h00, 0, 1, 0);
        chk("dec_wrap_A", bus.A, 8'hFF);
        chk("dec_wrap_flag", {7'd0, bus.Wrap}, 8'h01);
        step(0, 0, 0, 8'h00, 1, 1, 0);
        chk("both_A_hold", bus.A, 8'hFF);
        chk("both_wrap_hold", {7'd0, bus.Wrap}, 8'h01);

        // 4: collision, write wins and Wrap holds
        step(0, 1, 4, 8'h10, 0, 0, 0);
        step(0, 1, 4, 8'h77, 1, 0, 4);
        chk("coll_E", bus.E, 8'h77);
        chk("coll_wrap_hold", {7'd0, bus.Wrap}, 8'h01);

        // 5: parallel write and inc on different entries
        step(0, 1, 1, 8'h0F, 0, 0, 0);
        step(0, 1, 7, 8'hA5, 1, 0, 1);
        chk("par_H", bus.H, 8'hA5);
        chk("par_B", bus.B, 8'h10);
        chk("par_wrap", {7'd0, bus.Wrap}, 8'h00);

        // random mix, scoreboard-checked
        for (int n = 0; n < 60; n++)
            step(0, 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom));

        // 6: distinct loads, operand mux sweep, then reset overriding WE/IncEn
        for (int k = 0; k < 8; k++) step(0, 1, 3'(k), 8'(k * 17 + 3), 0, 0, 0);
        for (int s = 0; s < 8; s++) chk($sformatf("mux_s%0d", s), dut_reg(s), 8'(s * 17 + 3));
        step(1, 1, 5, 8'hEE, 1, 0, 6);
        for (int k = 0; k < 8; k++) chk("rst2_reg", dut_reg(k), 8'h00);
        chk("rst2_wrap", {7'd0, bus.Wrap}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
